// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I decode constants, immediate formats and immediate builder
package rv32i_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ULA_ADD   = 2'b00;
    localparam logic [1:0] ULA_BR    = 2'b01;
    localparam logic [1:0] ULA_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U
    } imm_fmt_e;

    // Reassemble the scattered immediate bits of each format into a 32-bit operand.
    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            default: imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two combinational reads with write-back bypass, x0 hardwired to zero
module reg_file
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    input  logic            i_we,
    input  logic [4:0]      i_wa,
    input  logic [XLEN-1:0] i_wd,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2
);

    logic [XLEN-1:0] r_regs [32];
    logic            w_wr_en;

    assign w_wr_en = i_we && (i_wa != 5'd0);

    // Register array: cleared on reset, x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Reads see a same-cycle write-back so the pipeline needs no extra WB forwarding.
    always_comb begin
        o_rd1 = '0;
        o_rd2 = '0;
        if (i_rs1 != 5'd0) begin
            o_rd1 = (w_wr_en && (i_wa == i_rs1)) ? i_wd : r_regs[i_rs1];
        end
        if (i_rs2 != 5'd0) begin
            o_rd2 = (w_wr_en && (i_wa == i_rs2)) ? i_wd : r_regs[i_rs2];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: IF/ID register, register file, decoder, load-use stall
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int          XLEN_P    = 32,
    parameter logic [31:0] NOP_WORD  = rv32i_pkg::NOP_INSTR
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_in,
    input  logic [XLEN_P-1:0] pc_in,
    input  logic              if_valid_in,
    input  logic              flush_in,
    input  logic              wb_reg_wr_in,
    input  logic [4:0]        wb_rd_in,
    input  logic [XLEN_P-1:0] wb_data_in,
    input  logic              ex_mem_rd_in,
    input  logic [4:0]        ex_rd_in,
    output logic [XLEN_P-1:0] pc_out,
    output logic [XLEN_P-1:0] imm_out,
    output logic [XLEN_P-1:0] val_A_out,
    output logic [XLEN_P-1:0] val_B_out,
    output logic [4:0]        rs1_out,
    output logic [4:0]        rs2_out,
    output logic [4:0]        rd_out,
    output logic [6:0]        funct7_out,
    output logic [2:0]        funct3_out,
    output logic [1:0]        ula_out,
    output logic              mux_ula_out,
    output logic              pc_ula_out,
    output logic              mem_rd_out,
    output logic              mem_wr_out,
    output logic              reg_wr_out,
    output logic              mux_reg_wr_out,
    output logic              stall_out,
    output logic              illegal_out
);

    logic [31:0]       r_instr;
    logic [XLEN_P-1:0] r_pc;
    logic              r_valid;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [1:0]  w_ula;
    logic        w_mux_ula;
    logic        w_pc_ula;
    logic        w_mem_rd;
    logic        w_mem_wr;
    logic        w_reg_wr;
    logic        w_mux_reg_wr;
    logic        w_legal;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    imm_fmt_e    w_fmt;
    logic        w_stall;
    logic        w_bubble;

    // IF/ID register: flush beats stall, stall holds, otherwise take the fetched slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= NOP_WORD;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (flush_in) begin
            r_instr <= NOP_WORD;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (!w_stall) begin
            r_instr <= instr_in;
            r_pc    <= pc_in;
            r_valid <= if_valid_in;
        end
    end

    assign w_opcode = r_instr[6:0];
    // LUI reads nothing; zeroing rs1 lets the ALU compute 0 + imm.
    assign w_rs1    = (w_opcode == OP_LUI) ? 5'd0 : r_instr[19:15];
    assign w_rs2    = r_instr[24:20];

    // Main decoder: control word, immediate format and source-register usage per opcode.
    always_comb begin
        w_ula        = ULA_ADD;
        w_mux_ula    = 1'b0;
        w_pc_ula     = 1'b0;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_reg_wr     = 1'b0;
        w_mux_reg_wr = 1'b0;
        w_legal      = 1'b1;
        w_uses_rs1   = 1'b0;
        w_uses_rs2   = 1'b0;
        w_fmt        = IMM_NONE;
        case (w_opcode)
            OP_R: begin
                w_ula      = ULA_FUNCT;
                w_reg_wr   = 1'b1;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            OP_IMM: begin
                w_ula      = ULA_FUNCT;
                w_mux_ula  = 1'b1;
                w_reg_wr   = 1'b1;
                w_uses_rs1 = 1'b1;
                w_fmt      = IMM_I;
            end
            OP_LOAD: begin
                w_mux_ula    = 1'b1;
                w_mem_rd     = 1'b1;
                w_reg_wr     = 1'b1;
                w_mux_reg_wr = 1'b1;
                w_uses_rs1   = 1'b1;
                w_fmt        = IMM_I;
            end
            OP_STORE: begin
                w_mux_ula  = 1'b1;
                w_mem_wr   = 1'b1;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
                w_fmt      = IMM_S;
            end
            OP_BRANCH: begin
                w_ula      = ULA_BR;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
                w_fmt      = IMM_B;
            end
            OP_LUI: begin
                w_mux_ula = 1'b1;
                w_reg_wr  = 1'b1;
                w_fmt     = IMM_U;
            end
            OP_AUIPC: begin
                w_mux_ula = 1'b1;
                w_pc_ula  = 1'b1;
                w_reg_wr  = 1'b1;
                w_fmt     = IMM_U;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // A load in EX whose destination feeds this instruction needs one bubble.
    assign w_stall  = r_valid && !flush_in && ex_mem_rd_in && (ex_rd_in != 5'd0) &&
                      (((ex_rd_in == w_rs1) && w_uses_rs1) || ((ex_rd_in == w_rs2) && w_uses_rs2));
    assign w_bubble = w_stall || !r_valid || flush_in;

    reg_file u_reg_file (
        .clk   (clk),
        .rst   (rst),
        .i_rs1 (w_rs1),
        .i_rs2 (w_rs2),
        .i_we  (wb_reg_wr_in),
        .i_wa  (wb_rd_in),
        .i_wd  (wb_data_in),
        .o_rd1 (val_A_out),
        .o_rd2 (val_B_out)
    );

    assign pc_out         = r_pc;
    assign imm_out        = gen_imm(r_instr, w_fmt);
    assign rs1_out        = w_rs1;
    assign rs2_out        = w_rs2;
    assign rd_out         = r_instr[11:7];
    assign funct7_out     = r_instr[31:25];
    assign funct3_out     = r_instr[14:12];
    assign ula_out        = w_bubble ? ULA_ADD : w_ula;
    assign mux_ula_out    = !w_bubble && w_mux_ula;
    assign pc_ula_out     = !w_bubble && w_pc_ula;
    assign mem_rd_out     = !w_bubble && w_mem_rd;
    assign mem_wr_out     = !w_bubble && w_mem_wr;
    assign reg_wr_out     = !w_bubble && w_reg_wr;
    assign mux_reg_wr_out = !w_bubble && w_mux_reg_wr;
    assign stall_out      = w_stall;
    assign illegal_out    = !w_bubble && !w_legal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage with directed steps and a behavioural model
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_in = 32'h13;
    logic [31:0] pc_in = '0;
    logic        if_valid_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        wb_reg_wr_in = 1'b0;
    logic [4:0]  wb_rd_in = '0;
    logic [31:0] wb_data_in = '0;
    logic        ex_mem_rd_in = 1'b0;
    logic [4:0]  ex_rd_in = '0;

    logic [31:0] pc_out, imm_out, val_A_out, val_B_out;
    logic [4:0]  rs1_out, rs2_out, rd_out;
    logic [6:0]  funct7_out;
    logic [2:0]  funct3_out;
    logic [1:0]  ula_out;
    logic        mux_ula_out, pc_ula_out, mem_rd_out, mem_wr_out;
    logic        reg_wr_out, mux_reg_wr_out, stall_out, illegal_out;

    decode_stage dut (
        .clk            (clk),
        .rst            (rst),
        .instr_in       (instr_in),
        .pc_in          (pc_in),
        .if_valid_in    (if_valid_in),
        .flush_in       (flush_in),
        .wb_reg_wr_in   (wb_reg_wr_in),
        .wb_rd_in       (wb_rd_in),
        .wb_data_in     (wb_data_in),
        .ex_mem_rd_in   (ex_mem_rd_in),
        .ex_rd_in       (ex_rd_in),
        .pc_out         (pc_out),
        .imm_out        (imm_out),
        .val_A_out      (val_A_out),
        .val_B_out      (val_B_out),
        .rs1_out        (rs1_out),
        .rs2_out        (rs2_out),
        .rd_out         (rd_out),
        .funct7_out     (funct7_out),
        .funct3_out     (funct3_out),
        .ula_out        (ula_out),
        .mux_ula_out    (mux_ula_out),
        .pc_ula_out     (pc_ula_out),
        .mem_rd_out     (mem_rd_out),
        .mem_wr_out     (mem_wr_out),
        .reg_wr_out     (reg_wr_out),
        .mux_reg_wr_out (mux_reg_wr_out),
        .stall_out      (stall_out),
        .illegal_out    (illegal_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       legal;
        logic [1:0] ula;
        logic       mux_ula;
        logic       pc_ula;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
        logic       mux_reg_wr;
        logic       u1;
        logic       u2;
    } ctl_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_valid;

    ctl_t        e_ctl;
    logic [31:0] e_imm, e_va, e_vb;
    logic [4:0]  e_rs1, e_rs2;
    logic        e_stall;

    function automatic ctl_t ctl_of(input logic [6:0] op);
        case (op)
            7'b0110011: return '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
            7'b0010011: return '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
            7'b0000011: return '{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
            7'b0100011: return '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            7'b1100011: return '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            7'b0110111: return '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            7'b0010111: return '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            default:    return '0;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] ins);
        int v;
        case (ins[6:0])
            7'b0010011, 7'b0000011: begin
                v = ins[31:20];
                if (v >= 2048) v -= 4096;
            end
            7'b0100011: begin
                v = ins[31:25] * 32 + ins[11:7];
                if (v >= 2048) v -= 4096;
            end
            7'b1100011: begin
                v = ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
                if (v >= 4096) v -= 8192;
            end
            7'b0110111, 7'b0010111: v = ins & 32'hFFFF_F000;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] rd_reg(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
        if (wb_reg_wr_in && wb_rd_in == idx) return wb_data_in;
        return m_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_instr = 32'h13;
        m_pc    = '0;
        m_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        ctl_t c;
        logic bubble;
        c       = ctl_of(m_instr[6:0]);
        e_rs1   = (m_instr[6:0] == 7'b0110111) ? 5'd0 : m_instr[19:15];
        e_rs2   = m_instr[24:20];
        e_imm   = imm_of(m_instr);
        e_va    = rd_reg(e_rs1);
        e_vb    = rd_reg(e_rs2);
        e_stall = m_valid && !flush_in && ex_mem_rd_in && ex_rd_in != 0 &&
                  ((ex_rd_in == e_rs1 && c.u1) || (ex_rd_in == e_rs2 && c.u2));
        bubble  = e_stall || !m_valid || flush_in;
        e_ctl   = bubble ? '0 : c;
        chk("pc", pc_out, m_pc);
        chk("imm", imm_out, e_imm);
        chk("val_A", val_A_out, e_va);
        chk("val_B", val_B_out, e_vb);
        chk("rs1", {27'd0, rs1_out}, {27'd0, e_rs1});
        chk("rs2", {27'd0, rs2_out}, {27'd0, e_rs2});
        chk("rd", {27'd0, rd_out}, {27'd0, m_instr[11:7]});
        chk("funct", {22'd0, funct7_out, funct3_out}, {22'd0, m_instr[31:25], m_instr[14:12]});
        chk("ctl", {23'd0, ula_out, mux_ula_out, pc_ula_out, mem_rd_out, mem_wr_out,
                    reg_wr_out, mux_reg_wr_out, illegal_out},
                   {23'd0, e_ctl.ula, e_ctl.mux_ula, e_ctl.pc_ula, e_ctl.mem_rd, e_ctl.mem_wr,
                    e_ctl.reg_wr, e_ctl.mux_reg_wr, !bubble && !c.legal});
        chk("stall", {31'd0, stall_out}, {31'd0, e_stall});
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                         input logic fl, input logic wbw, input logic [4:0] wbrd,
                         input logic [31:0] wbd, input logic exm, input logic [4:0] exrd);
        instr_in     = ins;
        pc_in        = pc;
        if_valid_in  = v;
        flush_in     = fl;
        wb_reg_wr_in = wbw;
        wb_rd_in     = wbrd;
        wb_data_in   = wbd;
        ex_mem_rd_in = exm;
        ex_rd_in     = exrd;
        #4;
        check_model();
    endtask

    task automatic tick();
        if (rst) begin
            model_reset();
        end else begin
            if (wb_reg_wr_in && wb_rd_in != 0) m_regs[wb_rd_in] = wb_data_in;
            if (flush_in) begin
                m_instr = 32'h13;
                m_pc    = '0;
                m_valid = 1'b0;
            end else if (!e_stall) begin
                m_instr = instr_in;
                m_pc    = pc_in;
                m_valid = if_valid_in;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [11];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
                7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011, 7'b0001111};
        ins        = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 10)];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    initial begin
        model_reset();
        // reset state
        drive(32'h13, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("reset_pc", pc_out, 32'h0);
        tick();
        rst = 1'b0;

        // addi x1,x0,-5
        drive(32'hFFB0_0093, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
        drive(32'h0040_01B3, 32'h104, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("addi_ula", {30'd0, ula_out}, 32'd2);
        chk("addi_mux_reg", {30'd0, mux_ula_out, reg_wr_out}, 32'd3);
        chk("addi_imm", imm_out, 32'hFFFF_FFFB);
        chk("addi_rd", {27'd0, rd_out}, 32'd1);
        tick();

        // load-use: add x3,x2,x4 behind a load to x2
        drive(32'h0041_01B3, 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
        drive(32'h0040_01B3, 32'h10C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2);
        chk("lu_stall", {31'd0, stall_out}, 32'd1);
        chk("lu_bubble", {31'd0, reg_wr_out}, 32'd0);
        tick();
        // held add issues; bypass of x4 in the same cycle
        drive(32'h0040_01B3, 32'h10C, 1'b1, 1'b0, 1'b1, 5'd4, 32'hDEAD_BEEF, 1'b0, 5'd0);
        chk("lu_issue_pc", pc_out, 32'h108);
        chk("lu_issue_wr", {31'd0, reg_wr_out}, 32'd1);
        chk("bypass_B", val_B_out, 32'hDEAD_BEEF);
        tick();
        // add x3,x0,x4 with a write-back to x0
        drive(32'h0000_0013, 32'h110, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
        chk("x0_bypass", val_A_out, 32'h0);
        chk("x4_stored", val_B_out, 32'hDEAD_BEEF);
        tick();

        // flush while a hazard is present: load add x3,x2,x4 again
        drive(32'h0041_01B3, 32'h114, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
        drive(32'h0041_01B3, 32'h118, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2);
        chk("flush_stall", {31'd0, stall_out}, 32'd0);
        chk("flush_ctl", {31'd0, reg_wr_out}, 32'd0);
        tick();
        drive(32'hFE53_2E23, 32'h11C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("flush_nop_rd", {27'd0, rd_out}, 32'd0);
        chk("flush_nop_wr", {31'd0, reg_wr_out}, 32'd0);
        tick();

        // immediates: sw, beq, lui, jal
        drive(32'hFE00_0CE3, 32'h120, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("sw_imm", imm_out, 32'hFFFF_FFFC);
        chk("sw_memwr", {31'd0, mem_wr_out}, 32'd1);
        tick();
        drive(32'h1234_53B7, 32'h124, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("beq_imm", imm_out, 32'hFFFF_FFF8);
        chk("beq_ula", {30'd0, ula_out}, 32'd1);
        tick();
        drive(32'h0000_00EF, 32'h128, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("lui_imm", imm_out, 32'h1234_5000);
        chk("lui_rs1", {27'd0, rs1_out}, 32'd0);
        tick();
        drive(32'h0041_01B3, 32'h12C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("jal_illegal", {31'd0, illegal_out}, 32'd1);
        tick();

        // reset asserted mid-stall
        drive(32'h0052_8333, 32'h130, 1'b1, 1'b0, 1'b1, 5'd5, 32'h5555_AAAA, 1'b1, 5'd2);
        chk("pre_rst_stall", {31'd0, stall_out}, 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        wb_reg_wr_in = 1'b0;
        check_model();
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_pc", pc_out, 32'h0);
        tick();
        rst = 1'b0;
        drive(32'h0052_8333, 32'h134, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
        drive(32'h13, 32'h138, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("rst_x5_A", val_A_out, 32'h0);
        chk("rst_x5_B", val_B_out, 32'h0);
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(rand_instr(), $urandom, ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the RV32I five-stage pipeline, directly upstream of the ID/EX pipeline register; its outputs connect 1:1 to the ID/EX `*_in` ports.
- Contains:
  - IF/ID pipeline register
  - 32x32 register file with write-back bypass
  - main decoder and immediate generator
  - load-use hazard detector, which inserts bubbles and stalls fetch

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- NOP_INSTR, 32'h0000_0013, instruction loaded into IF/ID on reset and flush (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- instr_in  in  32  fetched instruction.
- pc_in  in  32  PC of instr_in.
- if_valid_in  in  1  instr_in is valid.
- flush_in  in  1  taken branch resolved in EX; squash IF/ID.
- wb_reg_wr_in  in  1  write-back enable.
- wb_rd_in  in  5  write-back destination.
- wb_data_in  in  32  write-back data.
- ex_mem_rd_in  in  1  mem_rd of instruction currently in EX (from ID/EX).
- ex_rd_in  in  5  rd of instruction currently in EX.
- pc_out, imm_out, val_A_out, val_B_out  out  32 each  to ID/EX.
- rs1_out, rs2_out, rd_out  out  5 each  register indices.
- funct7_out  out  7;  funct3_out  out  3.
- ula_out  out  2  ALU op class: 00 add, 01 branch compare, 10 funct-decoded.
- mux_ula_out  out  1  ALU B = imm.
- pc_ula_out  out  1  ALU A = PC.
- mem_rd_out, mem_wr_out, reg_wr_out, mux_reg_wr_out  out  1 each  (mux_reg_wr: 1 = memory data).
- stall_out  out  1  hold PC and IF; ID/EX keeps enable=1 and captures the bubble.
- illegal_out  out  1  unsupported opcode in a valid IF/ID slot.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (rst).
  - On reset, IF/ID is loaded with NOP_INSTR, pc=0, valid=0, and all 32 registers are cleared.
  - Outputs after reset: every control output, stall_out and illegal_out are 0. pc/imm/val/rs/rd/funct outputs are 0.
- IF/ID register update at posedge, in priority order:
  1. flush_in: NOP_INSTR, valid=0.
  2. stall_out: hold.
  3. Otherwise: load instr_in, pc_in, valid=if_valid_in.
- Latency: an instruction accepted at edge N drives the outputs combinationally after N, and ID/EX captures it at N+1.
- Register file:
  - Write at posedge when wb_reg_wr_in && wb_rd_in!=0. x0 always reads 0.
  - Read is combinational with bypass: if wb_reg_wr_in && wb_rd_in==rsX && rsX!=0, return wb_data_in.
- Decode, by opcode (fields not listed are 0):
  - R 0110011: ula=10, reg_wr.
  - I-ALU 0010011: ula=10, mux_ula, reg_wr.
  - LOAD 0000011: ula=00, mux_ula, mem_rd, reg_wr, mux_reg_wr.
  - STORE 0100011: ula=00, mux_ula, mem_wr.
  - BRANCH 1100011: ula=01.
  - LUI 0110111: ula=00, mux_ula, reg_wr; rs1_out forced to 0 so val_A=0.
  - AUIPC 0010111: ula=00, mux_ula, pc_ula, reg_wr.
  - Any other opcode, including JAL/JALR, SYSTEM and FENCE: all controls 0, and illegal_out=1 if valid.
- Immediate: I/S/B/U formats sign-extended to 32 bits; B-format has bit0=0; U-format is imm[31:12]<<12; R-format gives 0.
- Source usage: uses_rs1 for R, I-ALU, LOAD, STORE, BRANCH, AUIPC=no, LUI=no. uses_rs2 for R, STORE, BRANCH only.
- Load-use hazard: stall_out = valid && !flush_in && ex_mem_rd_in && ex_rd_in!=0 && ((ex_rd_in==rs1 && uses_rs1) || (ex_rd_in==rs2 && uses_rs2)).
- Bubble:
  - When stall_out, !valid, or flush_in, all control outputs and illegal_out are 0.
  - Data outputs still reflect IF/ID contents.
- Simultaneous events:
  - flush_in overrides a stall.
  - A write-back that targets a register being read in the same cycle is bypassed.
  - A reset asserted mid-stall clears the stall on the next evaluation.

Decomposition:
- Package rv32i_pkg holds:
  - opcode localparams
  - ula encodings (ULA_ADD, ULA_BR, ULA_FUNCT)
  - NOP_INSTR
  - immediate-format enum
- Sub-module reg_file (2R1W, bypass, x0=0) instantiated once; decoder and hazard logic stay in decode_stage.

Test Plan:
1. Reset: assert rst mid-run -> all controls/stall/illegal=0, pc_out=0; read of x5 returns 0.
2. Load addi x1,x0,-5 (0xFFB00093) -> ula=10, mux_ula=1, reg_wr=1, imm_out=0xFFFFFFFB, rd_out=1.
3. Load-use: ex_mem_rd_in=1, ex_rd_in=2, IF/ID holds add x3,x2,x4 -> stall_out=1 and controls=0 for one cycle, IF/ID held. With ex_mem_rd_in=0 on the next cycle, add issues with reg_wr=1.
4. Write-back bypass: wb_reg_wr_in=1, wb_rd_in=4, wb_data_in=0xDEADBEEF while decoding an instruction reading x4 -> val_B_out=0xDEADBEEF the same cycle. A write to x0 is ignored, and val_A stays 0.
5. Flush with stall: flush_in=1 while a hazard is present -> stall_out=0, controls=0, and after the edge IF/ID holds NOP with valid=0.
6. Immediates:
   - sw x5,-4(x6) -> imm_out=0xFFFFFFFC, mem_wr=1.
   - beq offset -8 -> imm_out=0xFFFFFFF8, ula=01.
   - lui 0x12345 -> imm_out=0x12345000, rs1_out=0.
   - jal -> illegal_out=1.
